// File: rtl/mem_port_arbiter_if.sv
// Bundle of cache-port, debug-port and main-memory signals around mem_port_arbiter.
// slave = arbiter view, master = requesters plus memory model view.
interface mem_port_arbiter_if #(
  parameter int unsigned LINE_WORDS = 4
);
  localparam int unsigned BEAT_W = $clog2(LINE_WORDS);

  logic              i_req;
  logic [31:0]       i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic              i_done;

  logic              d_req;
  logic              d_we;
  logic [31:0]       d_addr;
  logic [31:0]       d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic              d_done;

  logic              dbg_req;
  logic              dbg_we;
  logic [31:0]       dbg_addr;
  logic [31:0]       dbg_wdata;
  logic              dbg_gnt;
  logic              dbg_done;

  logic [31:0]       rdata;
  logic [BEAT_W-1:0] beat;

  logic              mem_req;
  logic              mem_we;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ready;

  logic              cpu_stall;

  modport slave (
    input  i_req, i_addr,
    input  d_req, d_we, d_addr, d_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  mem_rdata, mem_ready,
    output i_gnt, i_rvalid, i_done,
    output d_gnt, d_rvalid, d_done,
    output dbg_gnt, dbg_done,
    output rdata, beat,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output cpu_stall
  );

  modport master (
    output i_req, i_addr,
    output d_req, d_we, d_addr, d_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output mem_rdata, mem_ready,
    input  i_gnt, i_rvalid, i_done,
    input  d_gnt, d_rvalid, d_done,
    input  dbg_gnt, dbg_done,
    input  rdata, beat,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  cpu_stall
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between I-cache refill, D-cache refill/write-back and debug loader.
// Line bursts for I/D, single words for debug; debug has priority, I/D alternate round-robin.
module mem_port_arbiter #(
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic              CPU_CLK,
  input  logic              CPU_RST,
  mem_port_arbiter_if.slave bus
);
  localparam int unsigned       BEAT_W    = $clog2(LINE_WORDS);
  localparam logic [31:0]       LINE_MASK = ~32'(4 * LINE_WORDS - 1);
  localparam logic [31:0]       WORD_MASK = ~32'(3);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_I,
    OWN_D,
    OWN_DBG
  } owner_e;

  state_e            state_q,     state_d;
  owner_e            owner_q,     owner_d;
  logic              rr_last_d_q, rr_last_d_d;  // 1 = D was the last I/D winner
  logic              we_q,        we_d;
  logic [31:0]       base_q,      base_d;
  logic [31:0]       dbg_wdata_q, dbg_wdata_d;
  logic [BEAT_W-1:0] beat_q,      beat_d;

  logic              busy;
  logic              fin;
  logic              own_i;
  logic              own_d;
  logic              own_dbg;
  logic              pick_d;
  logic              i_done_c;
  logic              d_done_c;
  logic [BEAT_W-1:0] end_beat;

  always_ff @(posedge CPU_CLK or negedge CPU_RST) begin
    if (!CPU_RST) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_NONE;
      rr_last_d_q <= 1'b0;
      we_q        <= 1'b0;
      base_q      <= '0;
      dbg_wdata_q <= '0;
      beat_q      <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_last_d_q <= rr_last_d_d;
      we_q        <= we_d;
      base_q      <= base_d;
      dbg_wdata_q <= dbg_wdata_d;
      beat_q      <= beat_d;
    end
  end

  // D wins when it is the only I/D requester or when I had the port last
  assign pick_d   = bus.d_req & (~bus.i_req | ~rr_last_d_q);
  assign end_beat = (owner_q == OWN_DBG) ? '0 : LAST_BEAT;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_last_d_d = rr_last_d_q;
    we_d        = we_q;
    base_d      = base_q;
    dbg_wdata_d = dbg_wdata_q;
    beat_d      = beat_q;
    unique case (state_q)
      ST_IDLE: begin
        owner_d = OWN_NONE;
        if (bus.dbg_req) begin
          state_d     = ST_BUSY;
          owner_d     = OWN_DBG;
          we_d        = bus.dbg_we;
          base_d      = bus.dbg_addr & WORD_MASK;
          dbg_wdata_d = bus.dbg_wdata;
        end else if (pick_d) begin
          state_d     = ST_BUSY;
          owner_d     = OWN_D;
          we_d        = bus.d_we;
          base_d      = bus.d_addr & LINE_MASK;
          rr_last_d_d = 1'b1;
        end else if (bus.i_req) begin
          state_d     = ST_BUSY;
          owner_d     = OWN_I;
          we_d        = 1'b0;
          base_d      = bus.i_addr & LINE_MASK;
          rr_last_d_d = 1'b0;
        end
      end
      ST_BUSY: begin
        if (bus.mem_ready) begin
          if (beat_q == end_beat) begin
            beat_d  = '0;
            state_d = ST_DONE;
          end else begin
            beat_d  = beat_q + BEAT_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  assign busy    = (state_q == ST_BUSY);
  assign fin     = (state_q == ST_DONE);
  assign own_i   = (owner_q == OWN_I);
  assign own_d   = (owner_q == OWN_D);
  assign own_dbg = (owner_q == OWN_DBG);

  assign i_done_c = fin & own_i;
  assign d_done_c = fin & own_d;

  assign bus.i_gnt    = (busy | fin) & own_i;
  assign bus.d_gnt    = (busy | fin) & own_d;
  assign bus.dbg_gnt  = (busy | fin) & own_dbg;
  assign bus.i_done   = i_done_c;
  assign bus.d_done   = d_done_c;
  assign bus.dbg_done = fin & own_dbg;

  assign bus.i_rvalid = busy & own_i & ~we_q & bus.mem_ready;
  assign bus.d_rvalid = busy & own_d & ~we_q & bus.mem_ready;

  assign bus.mem_req   = busy;
  assign bus.mem_we    = busy & we_q;
  assign bus.mem_addr  = busy ? (base_q + 32'({beat_q, 2'b00})) : '0;
  assign bus.mem_wdata = (busy & we_q) ? (own_dbg ? dbg_wdata_q : bus.d_wdata) : '0;

  assign bus.rdata = bus.mem_rdata;
  assign bus.beat  = beat_q;

  // Debug loads never hold the pipeline
  assign bus.cpu_stall = (bus.i_req & ~i_done_c) | (bus.d_req & ~d_done_c);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: cycle table for I/D bursts and wait states,
// hand sequences for debug priority, write-back data, debug write and mid-burst reset.
module tb_mem_port_arbiter;
  localparam int unsigned LW = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  mem_port_arbiter_if #(.LINE_WORDS(LW)) bus ();

  mem_port_arbiter #(.LINE_WORDS(LW)) dut (
    .CPU_CLK (clk),
    .CPU_RST (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: read data is a fixed scramble of the address, zero when idle
  assign bus.mem_rdata = bus.mem_req ? (bus.mem_addr ^ 32'hA5A5_0000) : 32'h0;

  typedef struct packed {
    logic        i_req;
    logic        d_req;
    logic        rdy;
    logic [2:0]  gnt;   // {dbg, d, i}
    logic [2:0]  done;  // {dbg, d, i}
    logic [1:0]  rv;    // {d, i}
    logic        mreq;
    logic [31:0] addr;
    logic [1:0]  beat;
    logic        stall;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic i, input logic d, input logic r, input logic [2:0] g,
                              input logic [2:0] dn, input logic [1:0] rv, input logic mq,
                              input logic [31:0] a, input logic [1:0] b, input logic st);
    vec_t v;
    v.i_req = i; v.d_req = d; v.rdy = r; v.gnt = g; v.done = dn; v.rv = rv;
    v.mreq = mq; v.addr = a; v.beat = b; v.stall = st;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_req = 0; bus.d_req = 0; bus.dbg_req = 0;
    bus.d_we = 0; bus.dbg_we = 0;
    bus.d_wdata = 0; bus.dbg_wdata = 0;
    bus.mem_ready = 1;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, " flags"}, 32'({bus.i_gnt, bus.i_rvalid, bus.i_done, bus.d_gnt, bus.d_rvalid,
                               bus.d_done, bus.dbg_gnt, bus.dbg_done, bus.mem_req, bus.mem_we,
                               bus.cpu_stall, bus.beat}), 32'h0);
    chk({name, " mem_addr"},  bus.mem_addr,  32'h0);
    chk({name, " mem_wdata"}, bus.mem_wdata, 32'h0);
    chk({name, " rdata"},     bus.rdata,     32'h0);
  endtask

  task automatic do_reset();
    tick();
    rst_n = 0;
    idle_inputs();
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    string nm;
    checks = 0;
    failures = 0;
    rst_n = 0;
    idle_inputs();
    bus.i_addr = 32'h1234; bus.d_addr = 32'h5678; bus.dbg_addr = 0;

    // Single I burst with a one-cycle idle afterwards
    vecs.push_back(mk(1, 0, 1, 3'b000, 3'b000, 2'b00, 0, 32'h0, 0, 1));
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(1, 0, 1, 3'b001, 3'b000, 2'b01, 1, 32'h1230 + 32'(4 * k), 2'(k), 1));
    vecs.push_back(mk(1, 0, 1, 3'b001, 3'b001, 2'b00, 0, 32'h0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 3'b000, 3'b000, 2'b00, 0, 32'h0, 0, 0));
    // I and D together, twice: D wins each time, I follows
    for (int rep = 0; rep < 2; rep++) begin
      vecs.push_back(mk(1, 1, 1, 3'b000, 3'b000, 2'b00, 0, 32'h0, 0, 1));
      for (int k = 0; k < 4; k++)
        vecs.push_back(mk(1, 1, 1, 3'b010, 3'b000, 2'b10, 1, 32'h5670 + 32'(4 * k), 2'(k), 1));
      vecs.push_back(mk(1, 1, 1, 3'b010, 3'b010, 2'b00, 0, 32'h0, 0, 1));
      vecs.push_back(mk(1, 0, 1, 3'b000, 3'b000, 2'b00, 0, 32'h0, 0, 1));
      for (int k = 0; k < 4; k++)
        vecs.push_back(mk(1, 0, 1, 3'b001, 3'b000, 2'b01, 1, 32'h1230 + 32'(4 * k), 2'(k), 1));
      vecs.push_back(mk(1, 0, 1, 3'b001, 3'b001, 2'b00, 0, 32'h0, 0, 0));
    end
    vecs.push_back(mk(0, 0, 1, 3'b000, 3'b000, 2'b00, 0, 32'h0, 0, 0));
    // D refill with three wait states on beat 2
    vecs.push_back(mk(0, 1, 1, 3'b000, 3'b000, 2'b00, 0, 32'h0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 3'b010, 3'b000, 2'b10, 1, 32'h5670, 0, 1));
    vecs.push_back(mk(0, 1, 1, 3'b010, 3'b000, 2'b10, 1, 32'h5674, 1, 1));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(0, 1, 0, 3'b010, 3'b000, 2'b00, 1, 32'h5678, 2, 1));
    vecs.push_back(mk(0, 1, 1, 3'b010, 3'b000, 2'b10, 1, 32'h5678, 2, 1));
    vecs.push_back(mk(0, 1, 1, 3'b010, 3'b000, 2'b10, 1, 32'h567C, 3, 1));
    vecs.push_back(mk(0, 1, 1, 3'b010, 3'b010, 2'b00, 0, 32'h0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 3'b000, 3'b000, 2'b00, 0, 32'h0, 0, 0));

    #3;
    chk_all_zero("por");
    @(negedge clk);
    rst_n = 1;

    foreach (vecs[n]) begin
      v = vecs[n];
      tick();
      bus.i_req = v.i_req; bus.d_req = v.d_req; bus.mem_ready = v.rdy;
      @(negedge clk);
      nm = $sformatf("vec%0d", n);
      chk({nm, " gnt"},   32'({bus.dbg_gnt, bus.d_gnt, bus.i_gnt}),    32'(v.gnt));
      chk({nm, " done"},  32'({bus.dbg_done, bus.d_done, bus.i_done}), 32'(v.done));
      chk({nm, " rvalid"}, 32'({bus.d_rvalid, bus.i_rvalid}),          32'(v.rv));
      chk({nm, " mem_req"}, 32'(bus.mem_req), 32'(v.mreq));
      chk({nm, " mem_addr"}, bus.mem_addr, v.addr);
      chk({nm, " beat"}, 32'(bus.beat), 32'(v.beat));
      chk({nm, " stall"}, 32'(bus.cpu_stall), 32'(v.stall));
      chk({nm, " rdata"}, bus.rdata, v.mreq ? (v.addr ^ 32'hA5A5_0000) : 32'h0);
    end

    // Debug beats I and D, then D, then I
    do_reset();
    tick();
    bus.dbg_req = 1; bus.dbg_addr = 32'h4007; bus.i_req = 1; bus.d_req = 1; bus.d_addr = 32'h200;
    @(negedge clk);
    chk("dbg c0 stall", 32'(bus.cpu_stall), 32'h1);
    chk("dbg c0 mem_req", 32'(bus.mem_req), 32'h0);
    tick(); @(negedge clk);
    chk("dbg c1 gnt", 32'({bus.dbg_gnt, bus.d_gnt, bus.i_gnt}), 32'b100);
    chk("dbg c1 mem_addr", bus.mem_addr, 32'h4004);
    chk("dbg c1 rdata", bus.rdata, 32'hA5A5_4004);
    chk("dbg c1 stall", 32'(bus.cpu_stall), 32'h1);
    tick(); @(negedge clk);
    chk("dbg c2 done", 32'({bus.dbg_done, bus.mem_req}), 32'b10);
    chk("dbg c2 stall", 32'(bus.cpu_stall), 32'h1);
    tick(); bus.dbg_req = 0; @(negedge clk);
    chk("dbg c3 idle", 32'({bus.dbg_gnt, bus.d_gnt, bus.i_gnt, bus.cpu_stall}), 32'b0001);
    tick(); @(negedge clk);
    chk("dbg c4 d_gnt", 32'({bus.d_gnt, bus.i_gnt}), 32'b10);
    chk("dbg c4 mem_addr", bus.mem_addr, 32'h200);
    for (int k = 0; k < 4; k++) tick();
    @(negedge clk);
    chk("dbg c8 d_done", 32'(bus.d_done), 32'h1);
    tick(); bus.d_req = 0; @(negedge clk);
    chk("dbg c9 stall", 32'({bus.i_gnt, bus.cpu_stall}), 32'b01);
    tick(); @(negedge clk);
    chk("dbg c10 i_gnt", 32'(bus.i_gnt), 32'h1);
    chk("dbg c10 mem_addr", bus.mem_addr, 32'h1230);
    for (int k = 0; k < 4; k++) tick();
    @(negedge clk);
    chk("dbg c14 i_done", 32'({bus.i_done, bus.cpu_stall}), 32'b10);
    tick(); bus.i_req = 0;

    // D write-back with live write data per beat
    tick();
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h200; bus.d_wdata = 32'h0;
    for (int k = 0; k < 4; k++) begin
      tick();
      bus.d_wdata = 32'hA0 + 32'(k);
      @(negedge clk);
      chk($sformatf("wb%0d mem_we", k), 32'({bus.mem_we, bus.d_gnt, bus.d_rvalid}), 32'b110);
      chk($sformatf("wb%0d mem_wdata", k), bus.mem_wdata, 32'hA0 + 32'(k));
      chk($sformatf("wb%0d mem_addr", k), bus.mem_addr, 32'h200 + 32'(4 * k));
    end
    tick(); @(negedge clk);
    chk("wb done", 32'({bus.d_done, bus.mem_we, bus.d_rvalid}), 32'b100);
    tick(); bus.d_req = 0; bus.d_we = 0;

    // Debug write keeps the data captured at grant
    tick();
    bus.dbg_req = 1; bus.dbg_we = 1; bus.dbg_addr = 32'h13; bus.dbg_wdata = 32'hDEAD_BEEF;
    tick(); bus.dbg_wdata = 32'h0; @(negedge clk);
    chk("dbgw mem_we", 32'({bus.mem_we, bus.mem_req, bus.cpu_stall}), 32'b110);
    chk("dbgw mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    chk("dbgw mem_addr", bus.mem_addr, 32'h10);
    tick(); @(negedge clk);
    chk("dbgw done", 32'(bus.dbg_done), 32'h1);
    tick(); bus.dbg_req = 0; bus.dbg_we = 0;

    // Reset during beat 2 of an I burst, then restart from the line base
    tick(); bus.i_req = 1; bus.i_addr = 32'h1234;
    tick(); tick(); tick();
    chk("rst pre beat", 32'(bus.beat), 32'h2);
    chk("rst pre mem_addr", bus.mem_addr, 32'h1238);
    #1;
    rst_n = 0; bus.i_req = 0;
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    rst_n = 1;
    tick(); bus.i_req = 1;
    tick(); @(negedge clk);
    chk("restart gnt", 32'({bus.i_gnt, bus.i_rvalid}), 32'b11);
    chk("restart beat", 32'(bus.beat), 32'h0);
    chk("restart mem_addr", bus.mem_addr, 32'h1230);
    for (int k = 0; k < 4; k++) tick();
    @(negedge clk);
    chk("restart done", 32'(bus.i_done), 32'h1);
    tick(); bus.i_req = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
